bsg_cache_pkt_arb: RTL and testbench

Round-robin arbiter that shares one bsg_cache packet port among num_req_p requesters and routes each cache response back to the requester that issued the matching packet. Sits between the requester tiles and the bsg_cache input and response ports. Tracks outstanding requests in an in-order ID FIFO; bsg_cache returns exactly one response per accepted packet, in order.

---
 rtl/bsg_cache_pkg.sv | 40 ++++
 rtl/bsg_cache_pkt_arb_id_fifo.sv | 58 +++++
 rtl/bsg_cache_pkt_arb.sv | 133 +++++++++++++
 tb/tb_bsg_cache_pkt_arb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_pkg.sv
// Shared bsg_cache definitions: opcodes, the packet layout, and the
// per-ID and lock-state types used by the packet arbiter.
package bsg_cache_pkg;

    typedef enum logic [5:0] {
        LB      = 6'b000000,
        LH      = 6'b000001,
        LW      = 6'b000010,
        SB      = 6'b001000,
        SH      = 6'b001001,
        SW      = 6'b001010,
        ALOCK   = 6'b011010,
        AUNLOCK = 6'b011011
    } bsg_cache_opcode_e;

    localparam int bsg_cache_opcode_width_lp = 6;

    // Reference layout for the default 32-bit build; opcode sits in the MSBs.
    typedef struct packed {
        bsg_cache_opcode_e opcode;
        logic [31:0]       addr;
        logic [31:0]       data;
        logic [3:0]        mask;
    } bsg_cache_pkt_s;

    // Flat packet width for arbitrary address/data widths.
    function automatic int bsg_cache_pkt_width(input int addr_w, input int data_w);
        return bsg_cache_opcode_width_lp + addr_w + data_w + data_w / 8;
    endfunction

    // Requester ID as held in the lock state (wide enough for any practical requester count).
    localparam int bsg_cache_arb_id_width_lp = 8;
    typedef logic [bsg_cache_arb_id_width_lp-1:0] bsg_cache_arb_id_t;

    typedef struct packed {
        logic              v;
        bsg_cache_arb_id_t id;
    } bsg_cache_arb_lock_s;

endpackage

// File: rtl/bsg_cache_pkt_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding cache packets.
// Pointers wrap at els_p so non-power-of-two depths work.
module bsg_cache_pkt_arb_id_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push,
    input  logic [width_p-1:0] data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [width_p-1:0] head
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem_r [els_p];
    logic [ptr_w-1:0]   wptr_r;
    logic [ptr_w-1:0]   rptr_r;
    logic [cnt_w-1:0]   count_r;
    logic               push_ok;
    logic               pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign full    = (count_r == cnt_w'(els_p));
    assign empty   = (count_r == '0);
    assign head    = mem_r[rptr_r];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_ok)
                wptr_r <= (wptr_r == ptr_w'(els_p - 1)) ? '0 : wptr_r + 1'b1;
            if (pop_ok)
                rptr_r <= (rptr_r == ptr_w'(els_p - 1)) ? '0 : rptr_r + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // ID storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_r[wptr_r] <= data;
    end

endmodule

// File: rtl/bsg_cache_pkt_arb.sv
// Round-robin arbiter sharing one bsg_cache packet port among num_req_p
// requesters; responses are steered back using an in-order ID FIFO.
// Optional feature: define BSG_CACHE_PKT_ARB_LOCK_EN to let ALOCK/AUNLOCK
// packets pin the grant to one requester.
module bsg_cache_pkt_arb
    import bsg_cache_pkg::*;
#(
    parameter int num_req_p    = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int fifo_els_p   = 4,
    localparam int bsg_cache_pkt_width_lp = bsg_cache_pkt_width(addr_width_p, data_width_p)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [num_req_p*bsg_cache_pkt_width_lp-1:0] req_pkt_i,
    input  logic [num_req_p-1:0]                     req_v_i,
    output logic [num_req_p-1:0]                     req_ready_o,
    output logic [num_req_p*data_width_p-1:0]        req_data_o,
    output logic [num_req_p-1:0]                     req_v_o,
    input  logic [num_req_p-1:0]                     req_yumi_i,
    output logic [bsg_cache_pkt_width_lp-1:0]        cache_pkt_o,
    output logic                                     cache_v_o,
    input  logic                                     cache_ready_i,
    input  logic [data_width_p-1:0]                  cache_data_i,
    input  logic                                     cache_v_i,
    output logic                                     cache_yumi_o
);

    localparam int pkt_w = bsg_cache_pkt_width_lp;
    localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic [pkt_w-1:0] pkt_arr [num_req_p];
    logic [id_w-1:0]  rr_r;
    logic [id_w-1:0]  grant;
    logic             found;
    int               idx;
    logic             transfer;
    logic             rr_advance;
    logic             fifo_full;
    logic             fifo_empty;
    logic [id_w-1:0]  head;

`ifdef BSG_CACHE_PKT_ARB_LOCK_EN
    bsg_cache_arb_lock_s lock_r;
    logic [5:0]          pkt_op;
    logic                unlock_xfer;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_req
            assign pkt_arr[gi] = req_pkt_i[gi*pkt_w +: pkt_w];
            assign req_ready_o[gi] = reset_n_i & found & (grant == id_w'(gi))
                                     & cache_ready_i & ~fifo_full;
            assign req_v_o[gi] = reset_n_i & cache_v_i & ~fifo_empty & (head == id_w'(gi));
            assign req_data_o[gi*data_width_p +: data_width_p] = cache_data_i;
        end
    endgenerate

    // Grant: first valid requester searching upward from rr_r with wrap; a held lock overrides.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(rr_r) + k;
            if (idx >= num_req_p)
                idx = idx - num_req_p;
            if (!found && req_v_i[idx]) begin
                found = 1'b1;
                grant = id_w'(idx);
            end
        end
`ifdef BSG_CACHE_PKT_ARB_LOCK_EN
        if (lock_r.v) begin
            grant = id_w'(lock_r.id);
            found = req_v_i[grant];
        end
`endif
    end

    assign cache_pkt_o  = pkt_arr[grant];
    assign cache_v_o    = reset_n_i & found & ~fifo_full;
    assign transfer     = cache_v_o & cache_ready_i;
    assign cache_yumi_o = reset_n_i & cache_v_i & ~fifo_empty & req_yumi_i[head];

`ifdef BSG_CACHE_PKT_ARB_LOCK_EN
    assign pkt_op      = cache_pkt_o[pkt_w-1 -: 6];
    assign unlock_xfer = lock_r.v & (pkt_op == AUNLOCK);
    assign rr_advance  = ~lock_r.v | unlock_xfer;

    // Lock state: ALOCK transfer while unlocked takes the lock, AUNLOCK from the holder releases it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_r <= '0;
        end else if (transfer) begin
            if (!lock_r.v && (pkt_op == ALOCK))
                lock_r <= '{v: 1'b1, id: bsg_cache_arb_id_t'(grant)};
            else if (unlock_xfer)
                lock_r.v <= 1'b0;
        end
    end
`else
    assign rr_advance = 1'b1;
`endif

    // Round-robin pointer moves just past the granted requester on each transfer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            rr_r <= '0;
        else if (transfer && rr_advance)
            rr_r <= (grant == id_w'(num_req_p - 1)) ? '0 : grant + 1'b1;
    end

    bsg_cache_pkt_arb_id_fifo #(
        .els_p   (fifo_els_p),
        .width_p (id_w)
    ) id_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push      (transfer),
        .data      (grant),
        .pop       (cache_yumi_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // A response with nothing outstanding is a cache protocol violation.
    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(cache_v_i && fifo_empty));

endmodule

// File: tb/tb_bsg_cache_pkt_arb.sv
// Scoreboard bench for bsg_cache_pkt_arb: stimulus pushes expected packets and
// responses; a negedge monitor pops and compares whenever the DUT transfers.
// Lock-specific expectations follow BSG_CACHE_PKT_ARB_LOCK_EN.
module tb_bsg_cache_pkt_arb;
    import bsg_cache_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FE = 4;
    localparam int PW = 6 + AW + DW + DW / 8;

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic [N*PW-1:0] req_pkt_i;
    logic [N-1:0]    req_v_i;
    logic [N-1:0]    req_ready_o;
    logic [N*DW-1:0] req_data_o;
    logic [N-1:0]    req_v_o;
    logic [N-1:0]    req_yumi_i;
    logic [PW-1:0]   cache_pkt_o;
    logic            cache_v_o;
    logic            cache_ready_i;
    logic [DW-1:0]   cache_data_i;
    logic            cache_v_i;
    logic            cache_yumi_o;

    always #5 clk = ~clk;

    bsg_cache_pkt_arb #(
        .num_req_p    (N),
        .addr_width_p (AW),
        .data_width_p (DW),
        .fifo_els_p   (FE)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .req_pkt_i     (req_pkt_i),
        .req_v_i       (req_v_i),
        .req_ready_o   (req_ready_o),
        .req_data_o    (req_data_o),
        .req_v_o       (req_v_o),
        .req_yumi_i    (req_yumi_i),
        .cache_pkt_o   (cache_pkt_o),
        .cache_v_o     (cache_v_o),
        .cache_ready_i (cache_ready_i),
        .cache_data_i  (cache_data_i),
        .cache_v_i     (cache_v_i),
        .cache_yumi_o  (cache_yumi_o)
    );

    typedef struct {
        logic [PW-1:0] pkt;
        int            req;
    } pkt_exp_t;

    typedef struct {
        int            req;
        logic [DW-1:0] data;
    } rsp_exp_t;

    pkt_exp_t      pq[$];
    rsp_exp_t      rq[$];
    logic [PW-1:0] cur_pkt [N];
    int            total = 0;
    int            bad   = 0;
    int            out_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mkpkt(input logic [5:0] op, input int r, input int n);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = 32'h1000 + 32'(r * 256 + n * 4);
        d = 32'hD000_0000 + 32'(r * 16 + n);
        return {op, a, d, 4'hF};
    endfunction

    task automatic set_pkt(input int r, input logic [PW-1:0] p);
        cur_pkt[r] = p;
        req_pkt_i[r*PW +: PW] = p;
    endtask

    task automatic exp_pkt(input int r);
        pq.push_back('{cur_pkt[r], r});
        $display("expect pkt from req %0d", r);
    endtask

    task automatic exp_rsp(input int r, input logic [DW-1:0] d);
        rq.push_back('{r, d});
        $display("expect rsp to req %0d data %0h", r, d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every packet transfer and every response consume is checked against the queues.
    initial begin
        pkt_exp_t pe;
        rsp_exp_t re;
        forever begin
            @(negedge clk);
            if (!reset_n_i) begin
                out_cnt = 0;
            end else begin
                if (cache_v_o && cache_ready_i) begin
                    chk("no_push_when_full", 128'(out_cnt < FE), 128'(1));
                    if (pq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pkt_unexpected: got %0h expected none", cache_pkt_o);
                    end else begin
                        pe = pq.pop_front();
                        chk("pkt", 128'(cache_pkt_o), 128'(pe.pkt));
                        chk("ready_onehot", 128'(req_ready_o), 128'(4'b1 << pe.req));
                        $display("pkt xfer req_ready=%b pkt=%0h", req_ready_o, cache_pkt_o);
                    end
                    out_cnt++;
                end
                if (cache_yumi_o) begin
                    if (rq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected: got req_v %b expected none", req_v_o);
                    end else begin
                        re = rq.pop_front();
                        chk("rsp_v", 128'(req_v_o), 128'(4'b1 << re.req));
                        chk("rsp_data", 128'(req_data_o[re.req*DW +: DW]), 128'(re.data));
                        $display("rsp yumi req_v=%b data=%0h", req_v_o, cache_data_i);
                    end
                    out_cnt--;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_order [4];
        int start;

        reset_n_i     = 1'b0;
        req_v_i       = '0;
        req_pkt_i     = '0;
        req_yumi_i    = '0;
        cache_ready_i = 1'b0;
        cache_data_i  = '0;
        cache_v_i     = 1'b0;
        for (int r = 0; r < N; r++)
            set_pkt(r, mkpkt(LW, r, 0));

        // Reset with active inputs: all outputs held at 0.
        repeat (2) @(posedge clk);
        #1;
        req_v_i       = 4'hF;
        cache_ready_i = 1'b1;
        @(negedge clk);
        chk("rst_ready", 128'(req_ready_o), 128'(0));
        chk("rst_cache_v", 128'(cache_v_o), 128'(0));
        chk("rst_req_v", 128'(req_v_o), 128'(0));
        chk("rst_yumi", 128'(cache_yumi_o), 128'(0));

        // Round robin with all requesters valid: 0,1,2,3 then FIFO full.
        step();
        reset_n_i = 1'b1;
        for (int r = 0; r < N; r++)
            exp_pkt(r);
        repeat (4) step();

        // Full FIFO with a response consumed: no push this cycle.
        cache_v_i    = 1'b1;
        cache_data_i = 32'h0000_00A0;
        req_yumi_i   = 4'hF;
        exp_rsp(0, 32'h0000_00A0);
        @(negedge clk);
        chk("full_cache_v", 128'(cache_v_o), 128'(0));
        chk("full_ready", 128'(req_ready_o), 128'(0));

        // Next cycle transfer resumes with requester 0 (rr wrapped).
        step();
        cache_v_i = 1'b0;
        exp_pkt(0);
        @(negedge clk);
        chk("resume_cache_v", 128'(cache_v_o), 128'(1));
        step();
        req_v_i = '0;

        // Drain in issue order 1,2,3,0.
        for (int k = 0; k < 4; k++) begin
            cache_v_i    = 1'b1;
            cache_data_i = 32'h0000_00B0 + 32'(k);
            exp_rsp((k + 1) % 4, 32'h0000_00B0 + 32'(k));
            step();
        end
        cache_v_i  = 1'b0;
        req_yumi_i = '0;

        // Requester 2 then 0 issue; rr is 1 so grants are 2 then 0.
        req_v_i = 4'b0100;
        exp_pkt(2);
        step();
        req_v_i = 4'b0001;
        exp_pkt(0);
        step();
        req_v_i = '0;

        // Non-head yumi is ignored; response routed to head requester 2.
        cache_v_i    = 1'b1;
        cache_data_i = 32'h0000_00D1;
        req_yumi_i   = 4'b0001;
        @(negedge clk);
        chk("nonhead_yumi", 128'(cache_yumi_o), 128'(0));
        chk("head_route", 128'(req_v_o), 128'(4'b0100));
        chk("data_bcast", 128'(req_data_o), {4{32'h0000_00D1}});
        step();
        req_yumi_i = 4'b0100;
        exp_rsp(2, 32'h0000_00D1);
        step();
        cache_data_i = 32'h0000_00D2;
        req_yumi_i   = 4'b0001;
        exp_rsp(0, 32'h0000_00D2);
        step();
        cache_v_i  = 1'b0;
        req_yumi_i = '0;

        // Requester 1 sends ALOCK, LW, AUNLOCK while everyone is valid (rr = 1).
        req_v_i = 4'hF;
        set_pkt(1, mkpkt(ALOCK, 1, 1));
        exp_pkt(1);
`ifdef BSG_CACHE_PKT_ARB_LOCK_EN
        lock_order = '{1, 1, 1, 2};
        start = 3;
        step();
        set_pkt(1, mkpkt(LW, 1, 2));
        exp_pkt(1);
        step();
        set_pkt(1, mkpkt(AUNLOCK, 1, 3));
        exp_pkt(1);
        step();
        set_pkt(1, mkpkt(LW, 1, 4));
        exp_pkt(2);
        step();
`else
        lock_order = '{1, 2, 3, 0};
        start = 1;
        exp_pkt(2);
        exp_pkt(3);
        exp_pkt(0);
        step();
        set_pkt(1, mkpkt(LW, 1, 2));
        step();
        set_pkt(1, mkpkt(AUNLOCK, 1, 3));
        step();
        set_pkt(1, mkpkt(LW, 1, 4));
        step();
`endif
        req_v_i    = '0;
        req_yumi_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            cache_v_i    = 1'b1;
            cache_data_i = 32'h0000_00E0 + 32'(k);
            exp_rsp(lock_order[k], 32'h0000_00E0 + 32'(k));
            step();
        end
        cache_v_i  = 1'b0;
        req_yumi_i = '0;

        // Three outstanding, then reset mid-operation.
        req_v_i = 4'hF;
        for (int k = 0; k < 3; k++)
            exp_pkt((start + k) % 4);
        repeat (3) step();
        cache_v_i    = 1'b1;
        cache_data_i = 32'h0000_00F0;
        req_yumi_i   = 4'hF;
        reset_n_i    = 1'b0;
        #1;
        chk("midrst_ready", 128'(req_ready_o), 128'(0));
        chk("midrst_cache_v", 128'(cache_v_o), 128'(0));
        chk("midrst_req_v", 128'(req_v_o), 128'(0));
        chk("midrst_yumi", 128'(cache_yumi_o), 128'(0));
        step();
        cache_v_i  = 1'b0;
        req_yumi_i = '0;
        step();

        // After release: rr back to 0 and FIFO empty, so four grants 0..3 then stall.
        reset_n_i = 1'b1;
        for (int r = 0; r < N; r++)
            exp_pkt(r);
        repeat (4) step();
        @(negedge clk);
        chk("post_rst_full", 128'(cache_v_o), 128'(0));
        step();
        req_v_i = '0;
        step();

        chk("pkt_queue_drained", 128'(pq.size()), 128'(0));
        chk("rsp_queue_drained", 128'(rq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
